// File: rtl/tmds_gearbox_pkg.sv
// Shared TMDS control symbols and elaboration-time helpers for the output gearbox.
package tmds_gearbox_pkg;

  localparam logic [9:0] CTRL0 = 10'b1101010100;
  localparam logic [9:0] CTRL1 = 10'b0010101011;
  localparam logic [9:0] CTRL2 = 10'b0101010100;
  localparam logic [9:0] CTRL3 = 10'b1010101011;

  // A word must split into a whole number of slices, and at least two of them.
  function automatic bit ratio_ok(input int word_width, input int slice_width);
    if (slice_width <= 0) return 1'b0;
    return ((word_width % slice_width) == 0) && ((word_width / slice_width) >= 2);
  endfunction

endpackage

// File: rtl/SyncFifo.sv
// Single-clock FIFO with registered occupancy; data written on one edge is poppable from the next.
module SyncFifo #(
  parameter int WIDTH      = 40,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  asyncResetN,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  // Occupancy never exceeds DEPTH, so its top bit alone signals full.
  assign full     = count[ADDR_WIDTH];
  assign empty    = (count == '0);
  assign level    = count;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tmds_gearbox.sv
// Multi-lane word-to-slice gearbox: buffers wide words in a FIFO and emits them R slices at a time.
module tmds_gearbox
  import tmds_gearbox_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int WORD_WIDTH      = 10,
  parameter int SLICE_WIDTH     = 5,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter bit MSB_FIRST       = 1'b1
) (
  input  logic                            clock,
  input  logic                            asyncResetN,
  input  logic                            enable,
  input  logic [CHANNELS*WORD_WIDTH-1:0]  wordData,
  input  logic                            wordValid,
  output logic                            wordReady,
  input  logic [CHANNELS*WORD_WIDTH-1:0]  fillWord,
  input  logic                            clearUnderflow,
  output logic [CHANNELS*SLICE_WIDTH-1:0] sliceData,
  output logic                            sliceValid,
  output logic                            underflow,
  output logic [FIFO_ADDR_WIDTH:0]        fifoLevel
);

  localparam int RATIO       = (SLICE_WIDTH > 0) ? WORD_WIDTH / SLICE_WIDTH : 0;
  localparam int PHASE_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BUS_WIDTH   = CHANNELS * WORD_WIDTH;
  localparam int OUT_WIDTH   = CHANNELS * SLICE_WIDTH;
  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(RATIO - 1);

  generate
    if (!ratio_ok(WORD_WIDTH, SLICE_WIDTH)) begin : g_bad_ratio
      $error("tmds_gearbox: WORD_WIDTH must be a multiple of SLICE_WIDTH with a ratio of at least 2");
    end
  endgenerate

  logic [PHASE_WIDTH-1:0] phase;
  logic [BUS_WIDTH-1:0]   hold;
  logic [BUS_WIDTH-1:0]   fifo_data;
  logic [BUS_WIDTH-1:0]   load_word;
  logic [BUS_WIDTH-1:0]   src_word;
  logic [OUT_WIDTH-1:0]   next_slice;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   load_phase;
  logic                   pop;
  logic                   primed;
  logic                   set_underflow;

  function automatic logic [SLICE_WIDTH-1:0] select_slice(
    input logic [WORD_WIDTH-1:0]  word,
    input logic [PHASE_WIDTH-1:0] idx
  );
    int shift;
    if (MSB_FIRST) shift = WORD_WIDTH - SLICE_WIDTH * (int'(idx) + 1);
    else           shift = SLICE_WIDTH * int'(idx);
    return SLICE_WIDTH'(word >> shift);
  endfunction

  SyncFifo #(
    .WIDTH      (BUS_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clock       (clock),
    .asyncResetN (asyncResetN),
    .push        (wordValid),
    .push_data   (wordData),
    .pop         (pop),
    .pop_data    (fifo_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (fifoLevel)
  );

  assign wordReady     = !fifo_full;
  assign sliceValid    = primed;
  assign load_phase    = enable && (phase == '0);
  assign pop           = load_phase && !fifo_empty;
  assign load_word     = fifo_empty ? fillWord : fifo_data;
  assign src_word      = (phase == '0) ? load_word : hold;
  assign set_underflow = load_phase && fifo_empty && primed;

  // At phase 0 the first slice comes straight from the word being loaded, not from the stale hold.
  always_comb begin
    next_slice = '0;
    for (int lane = 0; lane < CHANNELS; lane++) begin
      next_slice[lane*SLICE_WIDTH +: SLICE_WIDTH] =
        select_slice(src_word[lane*WORD_WIDTH +: WORD_WIDTH], phase);
    end
  end

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      phase     <= '0;
      hold      <= '0;
      sliceData <= '0;
      primed    <= 1'b0;
    end else if (enable) begin
      phase     <= (phase == LAST_PHASE) ? '0 : phase + PHASE_WIDTH'(1);
      sliceData <= next_slice;
      if (phase == '0) begin
        hold <= load_word;
        if (!fifo_empty) primed <= 1'b1;
      end
    end
  end

  // A fill load that coincides with a clear request still raises the flag.
  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN)        underflow <= 1'b0;
    else if (set_underflow)  underflow <= 1'b1;
    else if (clearUnderflow) underflow <= 1'b0;
  end

endmodule

// File: tb/tb_tmds_gearbox.sv
// Directed and randomised checks of tmds_gearbox against a queue-based behavioural model.
module tb_tmds_gearbox;
  import tmds_gearbox_pkg::*;

  localparam int CH    = 4;
  localparam int WW    = 10;
  localparam int SW    = 5;
  localparam int BW    = CH * WW;
  localparam int OW    = CH * SW;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          asyncResetN;
  logic          enable;
  logic          wordValid;
  logic          clearUnderflow;
  logic [BW-1:0] wordData;
  logic [BW-1:0] fillWord;
  logic          wordReady, sliceValid, underflow;
  logic [OW-1:0] sliceData;
  logic [3:0]    fifoLevel;

  logic          lsb_wordReady, lsb_sliceValid, lsb_underflow;
  logic [OW-1:0] lsb_sliceData;
  logic [3:0]    lsb_fifoLevel;

  logic          r4_wordValid;
  logic [7:0]    r4_wordData;
  logic          r4_wordReady, r4_sliceValid, r4_underflow;
  logic [1:0]    r4_sliceData;
  logic [3:0]    r4_fifoLevel;

  int vectors;
  int miscompares;

  tmds_gearbox dut (
    .clock(clock), .asyncResetN(asyncResetN), .enable(enable),
    .wordData(wordData), .wordValid(wordValid), .wordReady(wordReady),
    .fillWord(fillWord), .clearUnderflow(clearUnderflow),
    .sliceData(sliceData), .sliceValid(sliceValid), .underflow(underflow),
    .fifoLevel(fifoLevel)
  );

  tmds_gearbox #(.MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .asyncResetN(asyncResetN), .enable(enable),
    .wordData(wordData), .wordValid(wordValid), .wordReady(lsb_wordReady),
    .fillWord(fillWord), .clearUnderflow(clearUnderflow),
    .sliceData(lsb_sliceData), .sliceValid(lsb_sliceValid), .underflow(lsb_underflow),
    .fifoLevel(lsb_fifoLevel)
  );

  tmds_gearbox #(.CHANNELS(1), .WORD_WIDTH(8), .SLICE_WIDTH(2)) dut_r4 (
    .clock(clock), .asyncResetN(asyncResetN), .enable(enable),
    .wordData(r4_wordData), .wordValid(r4_wordValid), .wordReady(r4_wordReady),
    .fillWord(8'h00), .clearUnderflow(1'b0),
    .sliceData(r4_sliceData), .sliceValid(r4_sliceValid), .underflow(r4_underflow),
    .fifoLevel(r4_fifoLevel)
  );

  // Slice p of every lane, counted in emission order, from integer division of the lane value.
  function automatic logic [OW-1:0] lane_slices(input logic [BW-1:0] w, input int p, input bit msb_first);
    logic [OW-1:0] r;
    int value;
    int pos;
    r   = '0;
    pos = msb_first ? (WW / SW) - 1 - p : p;
    for (int n = 0; n < CH; n++) begin
      value = int'(w[n*WW +: WW]);
      r[n*SW +: SW] = SW'((value / (1 << (pos * SW))) % (1 << SW));
    end
    return r;
  endfunction

  logic [BW-1:0] m_q[$];
  int            m_phase;
  logic [BW-1:0] m_hold;
  logic [OW-1:0] m_msb;
  logic [OW-1:0] m_lsb;
  bit            m_primed;
  bit            m_underflow;

  // Reference behaviour of the default configuration, shared by the MSB-first and LSB-first instances.
  initial begin
    bit room;
    bit set_uf;
    m_phase = 0; m_primed = 0; m_underflow = 0; m_hold = '0; m_msb = '0; m_lsb = '0;
    forever begin
      @(posedge clock or negedge asyncResetN);
      if (!asyncResetN) begin
        m_q.delete();
        m_phase = 0; m_hold = '0; m_msb = '0; m_lsb = '0; m_primed = 0; m_underflow = 0;
      end else begin
        room   = (m_q.size() < DEPTH);
        set_uf = 0;
        if (enable) begin
          if (m_phase == 0) begin
            if (m_q.size() > 0) begin
              m_hold   = m_q.pop_front();
              m_primed = 1;
            end else begin
              set_uf = m_primed;
              m_hold = fillWord;
            end
          end
          m_msb   = lane_slices(m_hold, m_phase, 1'b1);
          m_lsb   = lane_slices(m_hold, m_phase, 1'b0);
          m_phase = (m_phase + 1) % (WW / SW);
        end
        if (set_uf) m_underflow = 1;
        else if (clearUnderflow) m_underflow = 0;
        if (wordValid && room) m_q.push_back(wordData);
      end
    end
  end

  task automatic do_reset();
    asyncResetN    = 1'b0;
    wordValid      = 1'b0;
    wordData       = '0;
    fillWord       = '0;
    clearUnderflow = 1'b0;
    r4_wordValid   = 1'b0;
    r4_wordData    = '0;
    repeat (2) @(negedge clock);
    asyncResetN = 1'b1;
  endtask

  task automatic test_reset();
    logic [BW-1:0] fill;
    enable         = 1'b1;
    asyncResetN    = 1'b0;
    clearUnderflow = 1'b0;
    wordValid      = 1'b1;
    wordData       = BW'({$urandom(), $urandom()});
    fill           = BW'({$urandom(), $urandom()});
    fillWord       = fill;
    r4_wordValid   = 1'b1;
    r4_wordData    = 8'hFF;
    repeat (3) @(negedge clock);
    vectors++;
    if (sliceData !== '0) begin
      miscompares++; $display("FAIL reset_slice: got %h want 0", sliceData);
    end
    vectors++;
    if ({lsb_sliceData, r4_sliceData} !== '0) begin
      miscompares++; $display("FAIL reset_slice_other: got %h want 0", {lsb_sliceData, r4_sliceData});
    end
    vectors++;
    if ({sliceValid, underflow} !== 2'b00) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00", {sliceValid, underflow});
    end
    vectors++;
    if (fifoLevel !== 4'd0) begin
      miscompares++; $display("FAIL reset_level: got %0d want 0", fifoLevel);
    end
    asyncResetN  = 1'b1;
    wordValid    = 1'b0;
    r4_wordValid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({wordReady, fifoLevel} !== {1'b1, 4'd0}) begin
      miscompares++; $display("FAIL release_ready: got %b/%0d want 1/0", wordReady, fifoLevel);
    end
    vectors++;
    if ({sliceValid, underflow} !== 2'b00) begin
      miscompares++; $display("FAIL unprimed_fill_flags: got %b want 00", {sliceValid, underflow});
    end
    vectors++;
    if (sliceData !== lane_slices(fill, 0, 1'b1)) begin
      miscompares++; $display("FAIL unprimed_fill_slice: got %h want %h", sliceData, lane_slices(fill, 0, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_msb[4];
    logic [4:0] exp_lsb[4];
    bit seen;
    exp_msb = '{5'h1D, 5'h05, 5'h07, 5'h10};
    exp_lsb = '{5'h05, 5'h1D, 5'h10, 5'h07};
    enable = 1'b1;
    do_reset();
    wordValid = 1'b1;
    wordData  = {30'($urandom()), 10'h3A5};
    @(negedge clock);
    vectors++;
    if (sliceValid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_valid_early: got %b want 0", sliceValid);
    end
    wordData = {30'($urandom()), 10'h0F0};
    @(negedge clock);
    wordValid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (sliceValid === 1'b1) seen = 1;
      else @(negedge clock);
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL b2b_prime_timeout: got sliceValid %b want 1", sliceValid);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (sliceData[4:0] !== exp_msb[k]) begin
        miscompares++; $display("FAIL b2b_msb[%0d]: got %h want %h", k, sliceData[4:0], exp_msb[k]);
      end
      vectors++;
      if (lsb_sliceData[4:0] !== exp_lsb[k]) begin
        miscompares++; $display("FAIL b2b_lsb[%0d]: got %h want %h", k, lsb_sliceData[4:0], exp_lsb[k]);
      end
      vectors++;
      if ({sliceValid, lsb_sliceValid, underflow} !== 3'b110) begin
        miscompares++; $display("FAIL b2b_flags[%0d]: got %b want 110", k, {sliceValid, lsb_sliceValid, underflow});
      end
      if (k < 3) @(negedge clock);
    end
  endtask

  task automatic test_underflow();
    bit seen;
    fillWord = {CH{CTRL0}};
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clock);
      if (underflow === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL uf_set_timeout: got %b want 1", underflow);
    end
    vectors++;
    if ({sliceData, lsb_sliceData} !== {{CH{5'h1A}}, {CH{5'h14}}}) begin
      miscompares++; $display("FAIL uf_fill_first: got %h/%h want %h/%h", sliceData, lsb_sliceData, {CH{5'h1A}}, {CH{5'h14}});
    end
    @(negedge clock);
    vectors++;
    if ({sliceData, underflow} !== {{CH{5'h14}}, 1'b1}) begin
      miscompares++; $display("FAIL uf_fill_second: got %h/%b want %h/1", sliceData, underflow, {CH{5'h14}});
    end
    clearUnderflow = 1'b1;
    @(negedge clock);
    vectors++;
    if ({sliceData, underflow} !== {{CH{5'h1A}}, 1'b1}) begin
      miscompares++; $display("FAIL uf_set_beats_clear: got %h/%b want %h/1", sliceData, underflow, {CH{5'h1A}});
    end
    @(negedge clock);
    clearUnderflow = 1'b0;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++; $display("FAIL uf_clear: got %b want 0", underflow);
    end
  endtask

  task automatic test_full();
    logic [BW-1:0] words[9];
    logic [BW-1:0] fill;
    logic [OW-1:0] want;
    enable = 1'b0;
    do_reset();
    fill     = BW'({$urandom(), $urandom()});
    fillWord = fill;
    for (int i = 0; i < 9; i++) begin
      words[i]  = BW'({$urandom(), $urandom()});
      wordValid = 1'b1;
      wordData  = words[i];
      @(negedge clock);
    end
    wordValid = 1'b0;
    vectors++;
    if ({fifoLevel, wordReady} !== {4'd8, 1'b0}) begin
      miscompares++; $display("FAIL full_level: got %0d/%b want 8/0", fifoLevel, wordReady);
    end
    vectors++;
    if ({sliceData, sliceValid, underflow} !== '0) begin
      miscompares++; $display("FAIL full_frozen: got %h/%b/%b want 0/0/0", sliceData, sliceValid, underflow);
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++) begin
        @(negedge clock);
        want = lane_slices(words[i], p, 1'b1);
        vectors++;
        if ({sliceData, sliceValid} !== {want, 1'b1}) begin
          miscompares++; $display("FAIL full_order w%0d p%0d: got %h/%b want %h/1", i, p, sliceData, sliceValid, want);
        end
        if (p == 0) begin
          vectors++;
          if (fifoLevel !== 4'(7 - i)) begin
            miscompares++; $display("FAIL full_drain w%0d: got %0d want %0d", i, fifoLevel, 7 - i);
          end
        end
      end
    end
    @(negedge clock);
    want = lane_slices(fill, 0, 1'b1);
    vectors++;
    if ({sliceData, underflow, fifoLevel} !== {want, 1'b1, 4'd0}) begin
      miscompares++; $display("FAIL full_ninth_dropped: got %h/%b/%0d want %h/1/0", sliceData, underflow, fifoLevel, want);
    end
  endtask

  task automatic test_reset_mid_word();
    bit seen;
    enable = 1'b1;
    do_reset();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wordValid = 1'b1;
      wordData  = BW'({$urandom(), $urandom()});
      @(negedge clock);
      if (m_phase == 1 && m_q.size() == 3) seen = 1;
    end
    wordValid = 1'b0;
    vectors++;
    if (!seen || fifoLevel !== 4'd3 || sliceValid !== 1'b1) begin
      miscompares++; $display("FAIL midreset_setup: got level %0d valid %b want 3/1", fifoLevel, sliceValid);
    end
    #2 asyncResetN = 1'b0;
    #1;
    vectors++;
    if ({sliceData, lsb_sliceData, sliceValid, underflow} !== '0) begin
      miscompares++; $display("FAIL midreset_outputs: got %h/%h/%b/%b want 0", sliceData, lsb_sliceData, sliceValid, underflow);
    end
    vectors++;
    if ({fifoLevel, wordReady} !== {4'd0, 1'b1}) begin
      miscompares++; $display("FAIL midreset_fifo: got %0d/%b want 0/1", fifoLevel, wordReady);
    end
    @(negedge clock);
    asyncResetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      vectors++;
      if ({sliceValid, underflow, fifoLevel} !== {2'b00, 4'd0}) begin
        miscompares++; $display("FAIL midreset_after[%0d]: got %b/%b/%0d want 0/0/0", i, sliceValid, underflow, fifoLevel);
      end
    end
    wordValid = 1'b1;
    wordData  = BW'({$urandom(), $urandom()});
    @(negedge clock);
    wordValid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clock);
      if (sliceValid === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || underflow !== 1'b0 || sliceData !== m_msb) begin
      miscompares++; $display("FAIL midreset_reprime: got %b/%b/%h want 1/0/%h", sliceValid, underflow, sliceData, m_msb);
    end
  endtask

  task automatic test_ratio4();
    logic [1:0] exp[4];
    bit seen;
    exp = '{2'd2, 2'd3, 2'd1, 2'd0};
    enable = 1'b1;
    do_reset();
    r4_wordValid = 1'b1;
    r4_wordData  = 8'hB4;
    @(negedge clock);
    r4_wordValid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (r4_sliceValid === 1'b1) seen = 1;
      else @(negedge clock);
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL r4_prime_timeout: got %b want 1", r4_sliceValid);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (r4_sliceData !== exp[k]) begin
        miscompares++; $display("FAIL r4_slice[%0d]: got %0d want %0d", k, r4_sliceData, exp[k]);
      end
      if (k < 3) @(negedge clock);
    end
    vectors++;
    if ({r4_underflow, r4_fifoLevel, r4_wordReady} !== {1'b0, 4'd0, 1'b1}) begin
      miscompares++; $display("FAIL r4_state: got %b/%0d/%b want 0/0/1", r4_underflow, r4_fifoLevel, r4_wordReady);
    end
  endtask

  task automatic test_random();
    logic [53:0] got;
    logic [53:0] want;
    bit m_ready;
    int wr_pct;
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      wr_pct         = ((i / 100) % 2 == 1) ? 80 : 25;
      enable         = ($urandom_range(0, 3) != 0);
      wordValid      = ($urandom_range(0, 99) < wr_pct);
      wordData       = BW'({$urandom(), $urandom()});
      clearUnderflow = ($urandom_range(0, 9) == 0);
      asyncResetN    = ($urandom_range(0, 249) != 0);
      case ($urandom_range(0, 3))
        0:       fillWord = {CH{CTRL1}};
        1:       fillWord = {CH{CTRL2}};
        2:       fillWord = {CH{CTRL3}};
        default: fillWord = BW'({$urandom(), $urandom()});
      endcase
      @(negedge clock);
      m_ready = (m_q.size() < DEPTH);
      got  = {sliceData, lsb_sliceData, sliceValid, lsb_sliceValid, underflow, lsb_underflow,
              fifoLevel, lsb_fifoLevel, wordReady, lsb_wordReady};
      want = {m_msb, m_lsb, m_primed, m_primed, m_underflow, m_underflow,
              4'(m_q.size()), 4'(m_q.size()), m_ready, m_ready};
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL random[%0d]: got %h want %h", i, got, want);
      end
    end
    asyncResetN    = 1'b1;
    wordValid      = 1'b0;
    clearUnderflow = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    enable         = 1'b1;
    asyncResetN    = 1'b0;
    wordValid      = 1'b0;
    wordData       = '0;
    fillWord       = '0;
    clearUnderflow = 1'b0;
    r4_wordValid   = 1'b0;
    r4_wordData    = '0;
    test_reset();
    test_back_to_back();
    test_underflow();
    test_full();
    test_reset_mid_word();
    test_ratio4();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tmds_gearbox.md
TMDS_GEARBOX -- requirements
Module: tmds_gearbox

Interface
REQ-001 Parameter CHANNELS, default 4: number of parallel lanes.
REQ-002 Parameter WORD_WIDTH, default 10: input word width per lane.
REQ-003 Parameter SLICE_WIDTH, default 5: output slice width per lane; R = WORD_WIDTH/SLICE_WIDTH SHALL be an integer >= 2, otherwise elaboration SHALL fail.
REQ-004 Parameter FIFO_ADDR_WIDTH, default 3: FIFO depth is 2^FIFO_ADDR_WIDTH words.
REQ-005 Parameter MSB_FIRST, default 1: 1 emits the upper slice first, 0 emits the lower slice first.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clock  in  1  sole clock; all state on its rising edge.
REQ-008 asyncResetN  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  clock enable for the read/gearbox side.
REQ-010 wordData  in  CHANNELS*WORD_WIDTH  input words; lane n occupies bits [n*WORD_WIDTH +: WORD_WIDTH].
REQ-011 wordValid  in  1  wordData is valid this cycle.
REQ-012 wordReady  out  1  FIFO can accept a word this cycle.
REQ-013 fillWord  in  CHANNELS*WORD_WIDTH  word substituted on underflow or before priming.
REQ-014 clearUnderflow  in  1  clears the sticky underflow flag.
REQ-015 sliceData  out  CHANNELS*SLICE_WIDTH  registered output slices, same lane packing as wordData.
REQ-016 sliceValid  out  1  high once primed; low while fill is emitted before priming.
REQ-017 underflow  out  1  sticky underflow flag.
REQ-018 fifoLevel  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy.

Function
REQ-019 A write SHALL occur when wordValid and wordReady are both high; wordReady SHALL equal (fifoLevel < 2^FIFO_ADDR_WIDTH), evaluated from registered state.
REQ-020 A write when full SHALL NOT occur, even if a read happens on the same edge.
REQ-021 The FIFO SHALL be non-fall-through: a word written on edge k SHALL NOT be readable before edge k+1.
REQ-022 A phase counter SHALL count 0..R-1 and wrap, advancing only on edges where enable is high.
REQ-023 On an enabled edge at phase 0, if the FIFO is non-empty, the block SHALL pop one word into the hold register and set sliceData to that word's first slice.
REQ-024 On an enabled edge at phase 0 with the FIFO empty, the block SHALL load fillWord instead.
REQ-025 On an enabled edge at phase p > 0, sliceData SHALL take slice p of the hold register.
REQ-026 With MSB_FIRST=1, slice p SHALL be bits [WORD_WIDTH-1-p*SLICE_WIDTH -: SLICE_WIDTH]; with MSB_FIRST=0, it SHALL be bits [p*SLICE_WIDTH +: SLICE_WIDTH].
REQ-027 When enable is low, the phase counter, hold register, sliceData and FIFO read SHALL be frozen; writes SHALL still be accepted.
REQ-028 The block SHALL be primed by the first real word popped; sliceValid SHALL go high on that same edge and stay high until reset.
REQ-029 Loading fillWord at phase 0 while primed SHALL set underflow; before priming it SHALL NOT.
REQ-030 clearUnderflow SHALL clear underflow on the next edge; if set and clear occur on the same edge, set SHALL win.
REQ-031 fifoLevel SHALL change by +1 on a write, -1 on a pop, and stay unchanged when both occur.

Reset
REQ-032 While asyncResetN is low: FIFO empty, fifoLevel=0, phase=0, hold register=0, sliceData=0, sliceValid=0, underflow=0, primed=0; wordReady=1 after release.
REQ-033 A reset asserted mid-word SHALL discard the partial word and all FIFO contents, with no spurious underflow after release.

Structure
REQ-034 Package tmds_gearbox_pkg SHALL hold the TMDS control symbols CTRL0..CTRL3 (CTRL0 = 10'b1101010100) and a ratio-check function.
REQ-035 The FIFO SHALL be a single sub-module SyncFifo (width CHANNELS*WORD_WIDTH, depth 2^FIFO_ADDR_WIDTH, level output).

Verification
REQ-036 Defaults, enable=1: write lane0 words 10'h3A5 then 10'h0F0 back-to-back -> lane0 slices 5'h1D, 5'h05, 5'h07, 5'h10 on consecutive edges, with sliceValid rising at the first.
REQ-037 MSB_FIRST=0, write 10'h3A5 -> lane0 slices 5'h05 then 5'h1D.
REQ-038 Prime, then stop writes, fillWord=CTRL0 on all lanes -> slices 5'h1A, 5'h14 per lane and underflow=1; assert clearUnderflow on a later fill phase -> underflow stays 1; assert it on a non-fill edge -> 0.
REQ-039 Write 9 words with enable=0 -> fifoLevel=8, wordReady=0, 9th word dropped; raise enable -> the 8 words emerge in order.
REQ-040 Assert asyncResetN low at phase 1 with fifoLevel=3 -> all outputs 0 immediately, fifoLevel=0, and no underflow before the next prime.
REQ-041 R=4 configuration (WORD_WIDTH=8, SLICE_WIDTH=2, CHANNELS=1): write 8'hB4 -> slices 2, 3, 1, 0.
